fir_tap_sequencer: RTL and testbench

//   Address/control generator for the FIR datapath; drives the tap-address register input.
//   Per accepted input sample: writes it into the circular sample buffer, then walks all taps
//   (sample address newest->oldest, coefficient address 0..TAPS-1) with MAC enables.

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_ptr_counter.sv | 20 ++
 rtl/fir_tap_sequencer.sv | 118 +++++++++++
 tb/tb_fir_tap_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants, FSM state type and run length for the FIR tap sequencer.
// FIR_SYMMETRIC_EN selects the folded linear-phase run length (TAPS/2).
package fir_pkg;

    localparam int TAPS   = 8;
    localparam int ADDR_W = $clog2(TAPS);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RUN,
        DONE
    } state_t;

    // Folded mode pairs tap k with its mirror, so only half the taps need a cycle.
    function automatic int run_len(input int taps);
`ifdef FIR_SYMMETRIC_EN
        return taps / 2;
`else
        return taps;
`endif
    endfunction

    localparam int RUN_LEN = run_len(TAPS);

endpackage

// File: rtl/fir_ptr_counter.sv
// rtl/fir_ptr_counter.sv - W-bit wrapping counter with synchronous reset, clear and increment enable.
module fir_ptr_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - buffer write and tap address/MAC control sequencer for the FIR datapath.
// FIR_SYMMETRIC_EN enables folded mode: TAPS/2 run cycles with a mirrored second read address.
module fir_tap_sequencer #(
    parameter int TAPS   = fir_pkg::TAPS,
    parameter int ADDR_W = fir_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [ADDR_W-1:0] data_addr2,
    output logic [ADDR_W-1:0] coef_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              out_valid
);

    import fir_pkg::*;

    localparam int                RUN_CYCLES = run_len(TAPS);
    localparam logic [ADDR_W-1:0] K_LAST     = ADDR_W'(RUN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] TAPS_M1    = ADDR_W'(TAPS - 1);

    state_t            state;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] tap_idx;
    logic [ADDR_W-1:0] tap_data;
    logic [ADDR_W-1:0] tap_data2;
    logic              accept;

    assign sample_ready = (state == IDLE) & ~rst;
    assign accept       = sample_valid & sample_ready;

    fir_ptr_counter #(.W(ADDR_W)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (state == DONE),
        .count (wptr)
    );

    fir_ptr_counter #(.W(ADDR_W)) u_k (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .inc   ((state == RUN) && (k != K_LAST)),
        .count (k)
    );

    // Outputs are registered, so they are loaded with the tap that the next cycle presents.
    always_comb begin
        tap_idx  = (state == WRITE) ? k : k + ADDR_W'(1);
        tap_data = wptr - tap_idx;
`ifdef FIR_SYMMETRIC_EN
        tap_data2 = wptr - (TAPS_M1 - tap_idx);
`else
        tap_data2 = tap_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            data_addr  <= '0;
            data_addr2 <= '0;
            coef_addr  <= '0;
            mac_clr    <= 1'b0;
            mac_en     <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= WRITE;
                        wr_en   <= 1'b1;
                        wr_addr <= wptr;
                        mac_clr <= 1'b1;
                    end
                end
                WRITE: begin
                    state      <= RUN;
                    mac_en     <= 1'b1;
                    coef_addr  <= tap_idx;
                    data_addr  <= tap_data;
                    data_addr2 <= tap_data2;
                end
                RUN: begin
                    if (k == K_LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        mac_en     <= 1'b1;
                        coef_addr  <= tap_idx;
                        data_addr  <= tap_data;
                        data_addr2 <= tap_data2;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - self-checking bench for fir_tap_sequencer; honours FIR_SYMMETRIC_EN.
module tb_fir_tap_sequencer;

    localparam int TAPS = 8;
    localparam int AW   = 3;
`ifdef FIR_SYMMETRIC_EN
    localparam int RL = TAPS / 2;
    int exp_d  [RL] = '{0, 7, 6, 5};
    int exp_d2 [RL] = '{1, 2, 3, 4};
`else
    localparam int RL = TAPS;
    int exp_d  [RL] = '{0, 7, 6, 5, 4, 3, 2, 1};
    int exp_d2 [RL] = '{0, 7, 6, 5, 4, 3, 2, 1};
`endif
    localparam int KR = RL / 2;

    logic          clk;
    logic          rst;
    logic          sample_valid;
    logic          sample_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] data_addr;
    logic [AW-1:0] data_addr2;
    logic [AW-1:0] coef_addr;
    logic          mac_clr;
    logic          mac_en;
    logic          out_valid;

    fir_tap_sequencer #(.TAPS(TAPS), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .data_addr    (data_addr),
        .data_addr2   (data_addr2),
        .coef_addr    (coef_addr),
        .mac_clr      (mac_clr),
        .mac_en       (mac_en),
        .out_valid    (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Timeline model: m_t counts cycles since acceptance (0 = idle).
    int m_t    = 0;
    int m_wptr = 0;
    bit m_ok   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_t    = 0;
            m_wptr = 0;
            m_ok   = 1;
        end else if (m_t == 0) begin
            if (sample_valid) m_t = 1;
        end else if (m_t == RL + 2) begin
            m_t    = 0;
            m_wptr = (m_wptr + 1) % TAPS;
        end else begin
            m_t++;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            int k;
            chk("sample_ready", 32'(sample_ready), 32'(m_t == 0 && !rst));
            chk("wr_en", 32'(wr_en), 32'(m_t == 1));
            chk("mac_clr", 32'(mac_clr), 32'(m_t == 1));
            chk("mac_en", 32'(mac_en), 32'(m_t >= 2 && m_t <= RL + 1));
            chk("out_valid", 32'(out_valid), 32'(m_t == RL + 2));
            if (m_t == 1) chk("wr_addr", 32'(wr_addr), 32'(m_wptr));
            if (m_t >= 2 && m_t <= RL + 1) begin
                k = m_t - 2;
                chk("coef_addr", 32'(coef_addr), 32'(k));
                chk("data_addr", 32'(data_addr), 32'((m_wptr - k + TAPS) % TAPS));
`ifdef FIR_SYMMETRIC_EN
                chk("data_addr2", 32'(data_addr2), 32'((m_wptr - (TAPS - 1 - k) + 2 * TAPS) % TAPS));
`else
                chk("data_addr2", 32'(data_addr2), 32'((m_wptr - k + TAPS) % TAPS));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dlog[$];
        int d2log[$];
        int clog[$];
        int wa[$];
        int wc[$];
        int ov_cyc;
        int ov_n;
        int wr_cyc;
        int wr_a;
        int c;

        // Reset behaviour
        rst = 1'b1;
        sample_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("t1_outputs_zero", 32'({wr_en, mac_clr, mac_en, out_valid, wr_addr, data_addr, data_addr2, coef_addr}), 32'd0);
        chk("t1_ready_in_rst", 32'(sample_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t1_ready_after_rst", 32'(sample_ready), 32'd1);

        // Single sample after reset, literal pins
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        ov_cyc = -1; ov_n = 0; wr_cyc = -1; wr_a = -1;
        for (int cc = 1; cc <= RL + 4; cc++) begin
            @(negedge clk);
            if (wr_en) begin wr_cyc = cc; wr_a = int'(wr_addr); end
            if (mac_en) begin
                dlog.push_back(int'(data_addr));
                d2log.push_back(int'(data_addr2));
                clog.push_back(int'(coef_addr));
            end
            if (out_valid) begin
                if (ov_cyc < 0) ov_cyc = cc;
                ov_n++;
            end
        end
        chk("t2_wr_cycle", 32'(wr_cyc), 32'd1);
        chk("t2_wr_addr", 32'(wr_a), 32'd0);
        chk("t2_out_valid_cycle", 32'(ov_cyc), 32'(RL + 2));
        chk("t2_out_valid_count", 32'(ov_n), 32'd1);
        chk("t2_run_length", 32'(dlog.size()), 32'(RL));
        for (int i = 0; i < RL; i++) begin
            if (i < dlog.size()) begin
                chk("t2_data_addr", 32'(dlog[i]), 32'(exp_d[i]));
                chk("t2_data_addr2", 32'(d2log[i]), 32'(exp_d2[i]));
                chk("t2_coef_addr", 32'(clog[i]), 32'(i));
            end
        end

        // Nine back-to-back samples from a fresh reset
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sample_valid = 1'b1;
        c = 0;
        while (wa.size() < 9 && c < 400) begin
            @(negedge clk);
            c++;
            if (wr_en) begin
                wa.push_back(int'(wr_addr));
                wc.push_back(c);
            end
        end
        sample_valid = 1'b0;
        chk("t3_accept_count", 32'(wa.size()), 32'd9);
        for (int i = 0; i < wa.size(); i++) begin
            chk("t3_wr_addr", 32'(wa[i]), 32'(i % TAPS));
            if (i > 0) chk("t3_gap", 32'(wc[i] - wc[i-1]), 32'(RL + 3));
        end
        dlog.delete();
        repeat (RL + 4) begin
            @(negedge clk);
            if (mac_en) dlog.push_back(int'(data_addr));
        end
        chk("t3_ninth_len", 32'(dlog.size()), 32'(RL));
        if (dlog.size() >= 2) begin
            chk("t3_ninth_first", 32'(dlog[0]), 32'd0);
            chk("t3_ninth_second", 32'(dlog[1]), 32'd7);
        end

        // Valid held while busy
        wc.delete();
        tick();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int cc = 1; cc <= 2 * RL + 8; cc++) begin
            @(negedge clk);
            if (cc == 3) sample_valid = 1'b1;
            if (wr_en) begin
                wc.push_back(cc);
                if (cc > 1) sample_valid = 1'b0;
            end
        end
        sample_valid = 1'b0;
        chk("t4_wr_count", 32'(wc.size()), 32'd2);
        if (wc.size() >= 2) begin
            chk("t4_first_wr", 32'(wc[0]), 32'd1);
            chk("t4_second_wr", 32'(wc[1]), 32'(RL + 4));
        end

        // Reset in the middle of RUN
        tick();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (KR + 1) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_mid_k", 32'(coef_addr), 32'(KR));
        chk("t5_mid_mac_en", 32'(mac_en), 32'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_after_mac_en", 32'(mac_en), 32'd0);
        chk("t5_after_ready", 32'(sample_ready), 32'd1);
        ov_n = 0;
        repeat (RL + 4) begin
            @(negedge clk);
            if (out_valid) ov_n++;
        end
        chk("t5_no_out_valid", 32'(ov_n), 32'd0);
        tick();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        @(negedge clk);
        chk("t5_rewrite_en", 32'(wr_en), 32'd1);
        chk("t5_rewrite_addr", 32'(wr_addr), 32'd0);
        repeat (RL + 4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
